gpio_irq_device: RTL and testbench

Next-generation memory-mapped GPIO peripheral on the peripheral bus, parametrised in pin count and input synchroniser depth. Adds atomic set/clear/toggle of outputs, per-pin level or edge interrupts with programmable polarity, and a sticky write-1-to-clear interrupt status register. Sits behind the peripheral bus device decode; drives one registered IRQ line to the core interrupt controller.

---
 rtl/gpio_irq_device.sv | 213 +++++++++++++++++++++
 tb/tb_gpio_irq_device.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_irq_device.sv
// Memory-mapped GPIO with atomic set/clear/toggle, per-pin level/edge interrupts and W1C status.
// Optional input debounce filter enabled by defining GPIO_DEBOUNCE_EN.
module gpio_irq_device #(
    parameter logic [3:0]  ID             = 4'h0,
    parameter int unsigned IO_COUNT       = 16,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned DEBOUNCE_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                peripheralEnable,
    input  logic                peripheralBus_we,
    input  logic                peripheralBus_oe,
    output logic                peripheralBus_busy,
    input  logic [15:0]         peripheralBus_address,
    input  logic [3:0]          peripheralBus_byteSelect,
    output logic [31:0]         peripheralBus_dataRead,
    input  logic [31:0]         peripheralBus_dataWrite,
    output logic                requestOutput,
    input  logic [IO_COUNT-1:0] gpio_input,
    output logic [IO_COUNT-1:0] gpio_output,
    output logic [IO_COUNT-1:0] gpio_oe,
    output logic                gpio_irq
);

    localparam logic [11:0] OFF_OE       = 12'h000;
    localparam logic [11:0] OFF_OUT      = 12'h004;
    localparam logic [11:0] OFF_SET      = 12'h008;
    localparam logic [11:0] OFF_CLR      = 12'h00C;
    localparam logic [11:0] OFF_TGL      = 12'h010;
    localparam logic [11:0] OFF_IN       = 12'h020;
    localparam logic [11:0] OFF_IRQ_EN   = 12'h030;
    localparam logic [11:0] OFF_IRQ_TYPE = 12'h034;
    localparam logic [11:0] OFF_IRQ_POL  = 12'h038;
    localparam logic [11:0] OFF_IRQ_BOTH = 12'h03C;
    localparam logic [11:0] OFF_STATUS   = 12'h040;
`ifdef GPIO_DEBOUNCE_EN
    localparam logic [11:0] OFF_DEBOUNCE = 12'h050;
`endif

    logic [IO_COUNT-1:0] r_oe;
    logic [IO_COUNT-1:0] r_out;
    logic [IO_COUNT-1:0] r_irq_en;
    logic [IO_COUNT-1:0] r_irq_type;
    logic [IO_COUNT-1:0] r_irq_pol;
    logic [IO_COUNT-1:0] r_irq_both;
    logic [IO_COUNT-1:0] r_status;
    logic [IO_COUNT-1:0] r_in_prev;
    logic                r_irq;
    logic [IO_COUNT-1:0] r_sync [SYNC_STAGES];

    logic [11:0]         w_off;
    logic                w_sel;
    logic                w_wr;
    logic                w_rd;
    logic [31:0]         w_lane_mask;
    logic [IO_COUNT-1:0] w_mask;
    logic [IO_COUNT-1:0] w_wd;
    logic [IO_COUNT-1:0] w_wd_m;
    logic [IO_COUNT-1:0] w_sync;
    logic [IO_COUNT-1:0] w_in;
    logic [IO_COUNT-1:0] w_rise;
    logic [IO_COUNT-1:0] w_fall;
    logic [IO_COUNT-1:0] w_edge_evt;
    logic [IO_COUNT-1:0] w_level_evt;
    logic [IO_COUNT-1:0] w_set;
    logic [IO_COUNT-1:0] w_w1c;
    logic [IO_COUNT-1:0] w_status_d;
    logic [31:0]         w_rdata;
    logic                w_req;
    logic                w_unused;

    assign w_off       = {peripheralBus_address[11:2], 2'b00};
    assign w_sel       = peripheralEnable && (peripheralBus_address[15:12] == ID);
    assign w_wr        = w_sel && peripheralBus_we;
    assign w_rd        = w_sel && peripheralBus_oe;
    assign w_lane_mask = {{8{peripheralBus_byteSelect[3]}}, {8{peripheralBus_byteSelect[2]}},
                          {8{peripheralBus_byteSelect[1]}}, {8{peripheralBus_byteSelect[0]}}};
    assign w_mask      = w_lane_mask[IO_COUNT-1:0];
    assign w_wd        = peripheralBus_dataWrite[IO_COUNT-1:0];
    assign w_wd_m      = w_wd & w_mask;
    assign w_unused    = ^{peripheralBus_address[1:0], peripheralBus_dataWrite, w_lane_mask};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= gpio_input;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [DEBOUNCE_WIDTH-1:0] DB_ONE = 1;

    logic [DEBOUNCE_WIDTH-1:0] r_debounce;
    logic [DEBOUNCE_WIDTH-1:0] r_db_cnt [IO_COUNT];
    logic [IO_COUNT-1:0]       r_in;
    logic [DEBOUNCE_WIDTH-1:0] w_db_mask;

    assign w_db_mask = w_lane_mask[DEBOUNCE_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_debounce <= '0;
        end else if (w_wr && (w_off == OFF_DEBOUNCE)) begin
            r_debounce <= (r_debounce & ~w_db_mask) |
                          (peripheralBus_dataWrite[DEBOUNCE_WIDTH-1:0] & w_db_mask);
        end
    end

    // IN follows the synchroniser only after DEBOUNCE+1 consecutive differing cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in <= '0;
            for (int unsigned i = 0; i < IO_COUNT; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < IO_COUNT; i++) begin
                if (w_sync[i] == r_in[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == r_debounce) begin
                    r_in[i]     <= w_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    assign w_in = r_in;
`else
    assign w_in = w_sync;
`endif

    assign w_rise      = w_in & ~r_in_prev;
    assign w_fall      = ~w_in & r_in_prev;
    assign w_edge_evt  = (r_irq_both & (w_rise | w_fall)) |
                         (~r_irq_both & ((r_irq_pol & w_rise) | (~r_irq_pol & w_fall)));
    assign w_level_evt = ~(w_in ^ r_irq_pol);
    assign w_set       = (r_irq_type & w_edge_evt) | (~r_irq_type & w_level_evt);
    assign w_w1c       = (w_wr && (w_off == OFF_STATUS)) ? w_wd_m : '0;
    // A set event in the same cycle as a W1C wins.
    assign w_status_d  = (r_status & ~w_w1c) | w_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_oe       <= '1;
            r_out      <= '0;
            r_irq_en   <= '0;
            r_irq_type <= '0;
            r_irq_pol  <= '0;
            r_irq_both <= '0;
            r_status   <= '0;
            r_in_prev  <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr) begin
                case (w_off)
                    OFF_OE:       r_oe       <= (r_oe & ~w_mask) | w_wd_m;
                    OFF_OUT:      r_out      <= (r_out & ~w_mask) | w_wd_m;
                    OFF_SET:      r_out      <= r_out | w_wd_m;
                    OFF_CLR:      r_out      <= r_out & ~w_wd_m;
                    OFF_TGL:      r_out      <= r_out ^ w_wd_m;
                    OFF_IRQ_EN:   r_irq_en   <= (r_irq_en & ~w_mask) | w_wd_m;
                    OFF_IRQ_TYPE: r_irq_type <= (r_irq_type & ~w_mask) | w_wd_m;
                    OFF_IRQ_POL:  r_irq_pol  <= (r_irq_pol & ~w_mask) | w_wd_m;
                    OFF_IRQ_BOTH: r_irq_both <= (r_irq_both & ~w_mask) | w_wd_m;
                    default: ;
                endcase
            end
            r_status  <= w_status_d;
            r_in_prev <= w_in;
            r_irq     <= |(r_status & r_irq_en);
        end
    end

    always_comb begin
        w_rdata = '1;
        w_req   = 1'b0;
        if (w_rd) begin
            w_req = 1'b1;
            case (w_off)
                OFF_OE:                   w_rdata = 32'(r_oe);
                OFF_OUT:                  w_rdata = 32'(r_out);
                OFF_SET, OFF_CLR, OFF_TGL: w_rdata = '0;
                OFF_IN:                   w_rdata = 32'(w_in);
                OFF_IRQ_EN:               w_rdata = 32'(r_irq_en);
                OFF_IRQ_TYPE:             w_rdata = 32'(r_irq_type);
                OFF_IRQ_POL:              w_rdata = 32'(r_irq_pol);
                OFF_IRQ_BOTH:             w_rdata = 32'(r_irq_both);
                OFF_STATUS:               w_rdata = 32'(r_status);
`ifdef GPIO_DEBOUNCE_EN
                OFF_DEBOUNCE:             w_rdata = 32'(r_debounce);
`endif
                default: begin
                    w_rdata = '1;
                    w_req   = 1'b0;
                end
            endcase
        end
    end

    assign peripheralBus_dataRead = w_rdata;
    assign requestOutput          = w_req;
    assign peripheralBus_busy     = 1'b0;
    assign gpio_output            = r_out;
    assign gpio_oe                = r_oe;
    assign gpio_irq               = r_irq;

endmodule

// File: tb/tb_gpio_irq_device.sv
// Directed self-checking bench for gpio_irq_device; covers the GPIO_DEBOUNCE_EN build when defined.
module tb_gpio_irq_device;

    localparam int IO   = 16;
    localparam int SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = SYNC + 1;
`else
    localparam int LAT = SYNC;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          we;
    logic          oe;
    logic          busy;
    logic [15:0]   addr;
    logic [3:0]    bsel;
    logic [31:0]   rdata;
    logic [31:0]   wdata;
    logic          rq;
    logic [IO-1:0] pins;
    logic [IO-1:0] gout;
    logic [IO-1:0] goe;
    logic          irq;

    int n_vec  = 0;
    int n_fail = 0;

    gpio_irq_device #(
        .ID             (4'h0),
        .IO_COUNT       (IO),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_WIDTH (16)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .peripheralEnable         (en),
        .peripheralBus_we         (we),
        .peripheralBus_oe         (oe),
        .peripheralBus_busy       (busy),
        .peripheralBus_address    (addr),
        .peripheralBus_byteSelect (bsel),
        .peripheralBus_dataRead   (rdata),
        .peripheralBus_dataWrite  (wdata),
        .requestOutput            (rq),
        .gpio_input               (pins),
        .gpio_output              (gout),
        .gpio_oe                  (goe),
        .gpio_irq                 (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge with the write applied.
    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] bs);
        en = 1'b1; we = 1'b1; addr = a; wdata = d; bsel = bs;
        @(negedge clk);
        en = 1'b0; we = 1'b0; bsel = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [31:0] exp_d,
                          input logic exp_rq);
        en = 1'b1; oe = 1'b1; addr = a;
        #1;
        chk(tag, rdata, exp_d);
        chk({tag, "_req"}, {31'b0, rq}, {31'b0, exp_rq});
        en = 1'b0; oe = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; oe = 1'b0;
        addr = '0; bsel = '0; wdata = '0; pins = '0;
        tick(3);

        // Reset state, read while reset is still asserted
        rd_chk("rst_oe", 16'h0000, 32'h0000_FFFF, 1'b1);
        rd_chk("rst_out", 16'h0004, 32'h0, 1'b1);
        rd_chk("rst_status", 16'h0040, 32'h0, 1'b1);
        rd_chk("unmapped_44", 16'h0044, 32'hFFFF_FFFF, 1'b0);
        rd_chk("wrong_id", 16'h1000, 32'hFFFF_FFFF, 1'b0);
`ifndef GPIO_DEBOUNCE_EN
        rd_chk("unmapped_50", 16'h0050, 32'hFFFF_FFFF, 1'b0);
`endif
        chk("rst_gpio_oe", 32'(goe), 32'h0000_FFFF);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;

        // Level-low default with all pins at 0 flags every pin
        tick(LAT + 2);
        rd_chk("lvl_default", 16'h0040, 32'h0000_FFFF, 1'b1);
        chk("irq_masked", {31'b0, irq}, 32'h0);

        // Output set/clear/toggle
        wr(16'h0004, 32'h0000_00F0, 4'hF);
        wr(16'h0008, 32'h0000_0003, 4'hF);
        wr(16'h000C, 32'h0000_0010, 4'hF);
        wr(16'h0010, 32'h0000_8001, 4'hF);
        chk("out_80e2", 32'(gout), 32'h0000_80E2);
        rd_chk("rd_out", 16'h0006, 32'h0000_80E2, 1'b1);
        wr(16'h0008, 32'h0000_FFFF, 4'b0010);
        chk("set_lane1", 32'(gout), 32'h0000_FFE2);
        rd_chk("rd_set_wo", 16'h0008, 32'h0, 1'b1);
        wr(16'h0000, 32'h0000_0000, 4'b0001);
        chk("oe_lane0", 32'(goe), 32'h0000_FF00);
        wr(16'h0000, 32'hFFFF_FFFF, 4'hF);
        rd_chk("oe_upper_ign", 16'h0000, 32'h0000_FFFF, 1'b1);

        // Switch to edge mode and clear stale status
        wr(16'h0034, 32'h0000_FFFF, 4'hF);
        wr(16'h0040, 32'h0000_FFFF, 4'hF);
        rd_chk("status_clr", 16'h0040, 32'h0, 1'b1);
        wr(16'h0038, 32'h0000_0001, 4'hF);
        wr(16'h0030, 32'h0000_0001, 4'hF);

        // IN latency; rising pins with falling polarity raise nothing
        pins = 16'h0A50;
        tick(LAT - 1);
        rd_chk("in_early", 16'h0020, 32'h0, 1'b1);
        tick(1);
        rd_chk("in_0a50", 16'h0020, 32'h0000_0A50, 1'b1);
        rd_chk("no_rise_evt", 16'h0040, 32'h0, 1'b1);

        // Pin0 rising edge -> status at LAT+1, irq at LAT+2
        pins[0] = 1'b1;
        tick(LAT);
        rd_chk("p0_st_early", 16'h0040, 32'h0, 1'b1);
        tick(1);
        rd_chk("p0_st_set", 16'h0040, 32'h1, 1'b1);
        chk("p0_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        chk("p0_irq_set", {31'b0, irq}, 32'h1);
        pins[0] = 1'b0;
        tick(LAT + 2);
        rd_chk("p0_fall_noop", 16'h0040, 32'h1, 1'b1);
        wr(16'h0040, 32'h0000_0001, 4'hF);
        rd_chk("p0_w1c", 16'h0040, 32'h0, 1'b1);
        chk("p0_irq_lag", {31'b0, irq}, 32'h1);
        tick(1);
        chk("p0_irq_clr", {31'b0, irq}, 32'h0);

        // Pin3 both-edges; W1C coinciding with falling-edge set keeps the bit
        wr(16'h003C, 32'h0000_0008, 4'hF);
        pins[3] = 1'b1;
        tick(LAT + 1);
        rd_chk("p3_rise", 16'h0040, 32'h8, 1'b1);
        wr(16'h0040, 32'h0000_0008, 4'hF);
        rd_chk("p3_w1c", 16'h0040, 32'h0, 1'b1);
        tick(1);
        pins[3] = 1'b0;
        tick(LAT);
        wr(16'h0040, 32'h0000_0008, 4'hF);
        rd_chk("p3_set_wins", 16'h0040, 32'h8, 1'b1);
        wr(16'h0040, 32'h0000_0008, 4'hF);
        rd_chk("p3_w1c2", 16'h0040, 32'h0, 1'b1);

        // Pin5 level-low: cannot clear while the condition holds
        wr(16'h0034, 32'h0000_FFDF, 4'hF);
        wr(16'h0030, 32'h0000_0021, 4'hF);
        rd_chk("p5_lvl", 16'h0040, 32'h20, 1'b1);
        tick(1);
        chk("p5_irq", {31'b0, irq}, 32'h1);
        wr(16'h0040, 32'h0000_0020, 4'hF);
        rd_chk("p5_w1c_held", 16'h0040, 32'h20, 1'b1);
        chk("p5_irq_held", {31'b0, irq}, 32'h1);
        pins[5] = 1'b1;
        tick(LAT + 1);
        rd_chk("p5_sticky", 16'h0040, 32'h20, 1'b1);
        wr(16'h0040, 32'h0000_0020, 4'hF);
        rd_chk("p5_cleared", 16'h0040, 32'h0, 1'b1);
        tick(1);
        chk("p5_irq_clr", {31'b0, irq}, 32'h0);

        // Reset mid-operation
        pins[5] = 1'b0;
        tick(LAT + 2);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_out", 32'(gout), 32'h0);
        chk("mid_rst_oe", 32'(goe), 32'h0000_FFFF);
        rd_chk("mid_rst_status", 16'h0040, 32'h0, 1'b1);
        rd_chk("mid_rst_in", 16'h0020, 32'h0, 1'b1);
        rd_chk("mid_rst_en", 16'h0030, 32'h0, 1'b1);
        rst = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
        wr(16'h0050, 32'h0000_0003, 4'hF);
        rd_chk("db_reg", 16'h0050, 32'h3, 1'b1);
        tick(10);
        rd_chk("db_settled", 16'h0020, 32'h0000_0A50, 1'b1);
        pins[7] = 1'b1;
        tick(2);
        pins[7] = 1'b0;
        tick(8);
        rd_chk("db_glitch", 16'h0020, 32'h0000_0A50, 1'b1);
        pins[7] = 1'b1;
        tick(SYNC + 3);
        rd_chk("db_hold_early", 16'h0020, 32'h0000_0A50, 1'b1);
        tick(1);
        rd_chk("db_hold", 16'h0020, 32'h0000_0AD0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
